// File: rtl/pipe_robot_controller.sv
// Robot-side controller for the pipe-cleaning world: wall search, left-hand wall following,
// multi-cycle trash removal and halt on the exit cell. All command outputs are registered.
module pipe_robot_controller #(
    parameter int REMOVE_CYCLES = 3,
    parameter int SETTLE_CYCLES = 1,
    parameter int COUNT_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               head,
    input  logic               left,
    input  logic               under,
    input  logic               barrier,
    output logic               front,
    output logic               turn,
    output logic               remove,
    output logic               done,
    output logic [COUNT_W-1:0] trash_count
);

    localparam int REM_W = (REMOVE_CYCLES < 2) ? 1 : $clog2(REMOVE_CYCLES + 1);
    localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_SEARCH,
        S_FOLLOW,
        S_FWD_LEFT,
        S_ROTATE,
        S_REMOVE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             r_ret_state;
    state_t             r_rot_next;
    logic [1:0]         r_turn_cnt;
    logic [REM_W-1:0]   r_rem_cnt;
    logic [SET_W-1:0]   r_settle_cnt;
    logic               r_ignore_left;
    logic               r_front;
    logic               r_turn;
    logic               r_remove;
    logic               r_done;
    logic [COUNT_W-1:0] r_trash_count;
    state_t             w_after_remove;

    // A removal started from the post-left-turn step resumes plain wall following.
    assign w_after_remove = (r_ret_state == S_FWD_LEFT) ? S_FOLLOW : r_ret_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_SEARCH;
            r_ret_state   <= S_SEARCH;
            r_rot_next    <= S_SEARCH;
            r_turn_cnt    <= 2'd0;
            r_rem_cnt     <= '0;
            r_settle_cnt  <= '0;
            r_ignore_left <= 1'b0;
            r_front       <= 1'b0;
            r_turn        <= 1'b0;
            r_remove      <= 1'b0;
            r_done        <= 1'b0;
            r_trash_count <= '0;
        end else begin
            r_front  <= 1'b0;
            r_turn   <= 1'b0;
            r_remove <= 1'b0;
            case (r_state)
                S_SEARCH, S_FOLLOW, S_FWD_LEFT: begin
                    if (r_state == S_FOLLOW) r_ignore_left <= 1'b0;
                    if (under) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (barrier) begin
                        r_remove    <= 1'b1;
                        r_rem_cnt   <= REM_W'(1);
                        r_ret_state <= r_state;
                        r_state     <= S_REMOVE;
                    end else if (r_state == S_FOLLOW && !left && !r_ignore_left) begin
                        r_turn       <= 1'b1;
                        r_ret_state  <= S_FWD_LEFT;
                        r_settle_cnt <= SETTLE_INIT;
                        r_state      <= S_SETTLE;
                    end else if (!head) begin
                        r_front      <= 1'b1;
                        r_ret_state  <= (r_state == S_SEARCH) ? S_SEARCH : S_FOLLOW;
                        r_settle_cnt <= SETTLE_INIT;
                        r_state      <= S_SETTLE;
                    end else begin
                        // First of the three turns goes out on the deciding edge itself.
                        r_turn       <= 1'b1;
                        r_turn_cnt   <= 2'd2;
                        r_rot_next   <= S_FOLLOW;
                        r_ret_state  <= S_ROTATE;
                        r_settle_cnt <= SETTLE_INIT;
                        r_state      <= S_SETTLE;
                        if (r_state == S_FWD_LEFT) r_ignore_left <= 1'b1;
                    end
                end
                S_ROTATE: begin
                    r_turn       <= 1'b1;
                    r_turn_cnt   <= r_turn_cnt - 2'd1;
                    r_ret_state  <= (r_turn_cnt == 2'd1) ? r_rot_next : S_ROTATE;
                    r_settle_cnt <= SETTLE_INIT;
                    r_state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle_cnt <= SET_W'(1)) r_state <= r_ret_state;
                    else r_settle_cnt <= r_settle_cnt - 1'b1;
                end
                S_REMOVE: begin
                    if (r_rem_cnt < REM_W'(REMOVE_CYCLES)) begin
                        r_remove  <= 1'b1;
                        r_rem_cnt <= r_rem_cnt + 1'b1;
                    end else begin
                        if (r_trash_count != {COUNT_W{1'b1}})
                            r_trash_count <= r_trash_count + 1'b1;
                        // This edge already opens the first idle cycle of the settle window.
                        if (SETTLE_CYCLES > 1) begin
                            r_ret_state  <= w_after_remove;
                            r_settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                            r_state      <= S_SETTLE;
                        end else begin
                            r_state <= w_after_remove;
                        end
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= S_SEARCH;
                end
            endcase
        end
    end

    assign front       = r_front;
    assign turn        = r_turn;
    assign remove      = r_remove;
    assign done        = r_done;
    assign trash_count = r_trash_count;

endmodule

// File: tb/tb_pipe_robot_controller.sv
// Bench for pipe_robot_controller: a command-sequence reference model (queue of expected
// per-cycle outputs) compared every cycle, plus directed literal checks.
module tb_pipe_robot_controller;

    localparam int COUNT_W       = 8;
    localparam int REMOVE_CYCLES = 3;
    localparam int SETTLE_CYCLES = 1;
    localparam int M_SEARCH      = 0;
    localparam int M_FOLLOW      = 1;
    localparam int M_AFTER_LEFT  = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic               head;
    logic               left;
    logic               under;
    logic               barrier;
    logic               front;
    logic               turn;
    logic               remove;
    logic               done;
    logic [COUNT_W-1:0] trash_count;

    int n_total = 0;
    int n_bad   = 0;

    // Each entry is one output cycle: {front, turn, remove, count_increment}.
    logic [3:0]         exp_q[$];
    logic [3:0]         m_cur;
    int                 m_mode;
    logic               m_ignore;
    logic               m_done;
    logic [COUNT_W-1:0] m_count;

    pipe_robot_controller #(
        .REMOVE_CYCLES(REMOVE_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .COUNT_W(COUNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .head(head),
        .left(left),
        .under(under),
        .barrier(barrier),
        .front(front),
        .turn(turn),
        .remove(remove),
        .done(done),
        .trash_count(trash_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cur    = 4'b0000;
        m_mode   = M_SEARCH;
        m_ignore = 1'b0;
        m_done   = 1'b0;
        m_count  = '0;
    endtask

    task automatic push_cmd(input logic f, input logic t);
        exp_q.push_back({f, t, 2'b00});
        for (int i = 0; i < SETTLE_CYCLES; i++) exp_q.push_back(4'b0000);
    endtask

    task automatic push_rotation();
        for (int i = 0; i < 3; i++) push_cmd(1'b0, 1'b1);
    endtask

    task automatic push_removal();
        for (int i = 0; i < REMOVE_CYCLES; i++) exp_q.push_back(4'b0010);
        for (int i = 0; i < SETTLE_CYCLES; i++) exp_q.push_back((i == 0) ? 4'b0001 : 4'b0000);
    endtask

    task automatic model_decide();
        logic ign;
        ign = m_ignore;
        if (m_mode == M_FOLLOW) m_ignore = 1'b0;
        if (m_done) begin
            exp_q.push_back(4'b0000);
        end else if (under) begin
            m_done = 1'b1;
            exp_q.push_back(4'b0000);
        end else if (barrier) begin
            if (m_mode == M_AFTER_LEFT) m_mode = M_FOLLOW;
            push_removal();
        end else if (m_mode == M_SEARCH) begin
            if (!head) push_cmd(1'b1, 1'b0);
            else begin push_rotation(); m_mode = M_FOLLOW; end
        end else if (m_mode == M_FOLLOW) begin
            if (!left && !ign) begin push_cmd(1'b0, 1'b1); m_mode = M_AFTER_LEFT; end
            else if (!head) push_cmd(1'b1, 1'b0);
            else push_rotation();
        end else begin
            m_mode = M_FOLLOW;
            if (!head) push_cmd(1'b1, 1'b0);
            else begin push_rotation(); m_ignore = 1'b1; end
        end
    endtask

    task automatic model_step();
        if (exp_q.size() == 0) model_decide();
        m_cur = exp_q.pop_front();
        if (m_cur[0] && m_count != {COUNT_W{1'b1}}) m_count = m_count + 1'b1;
    endtask

    task automatic compare_outputs();
        chk("cycle", {20'd0, front, turn, remove, done, trash_count},
                     {20'd0, m_cur[3], m_cur[2], m_cur[1], m_done, m_count});
    endtask

    // Drive sensors, let one rising edge happen, advance the model, compare 1ns later.
    task automatic tick(input logic h, input logic l, input logic u, input logic b);
        head    = h;
        left    = l;
        under   = u;
        barrier = b;
        @(posedge clock);
        model_step();
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("reset_outputs", {20'd0, front, turn, remove, done, trash_count}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [11:0] fseq;
        logic [11:0] tseq;
        logic [3:0]  rseq;
        int          nturns;
        logic        cmd_or;

        reset   = 1'b1;
        head    = 1'b0;
        left    = 1'b1;
        under   = 1'b0;
        barrier = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_hold", {20'd0, front, turn, remove, done, trash_count}, 32'd0);
        reset = 1'b0;

        // Reset arriving between edges in the middle of a removal.
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("remove_before_reset", {31'd0, remove}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_remove", {31'd0, remove}, 32'd0);
        chk("async_reset_count", {24'd0, trash_count}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("first_cmd_front", {31'd0, front}, 32'd1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Search: three forward steps, then a wall ahead triggers three turns.
        for (int i = 0; i < 12; i++) begin
            tick((i < 6) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0);
            fseq[i] = front;
            tseq[i] = turn;
        end
        chk("search_front_seq", {20'd0, fseq}, 32'h015);
        chk("search_turn_seq", {20'd0, tseq}, 32'h540);

        // Trash ahead while following.
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b0, (i == 0) ? 1'b1 : 1'b0);
            rseq[i] = remove;
        end
        chk("remove_seq", {28'd0, rseq}, 32'h7);
        chk("count_after_remove", {24'd0, trash_count}, 32'd1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("front_after_remove", {31'd0, front}, 32'd1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Open left: turn, step forward, then a normal corner turn.
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("left_turn", {30'd0, front, turn}, 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("fwd_after_left", {30'd0, front, turn}, 32'd2);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("normal_corner", {30'd0, front, turn}, 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Blocked after the left turn: right turn, then left opening ignored once.
        nturns = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            if (turn) nturns++;
        end
        chk("spin_turns", nturns, 32'd3);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ignore_left_front", {30'd0, front, turn}, 32'd2);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int i = 0; i < 400; i++)
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // Exit wins over trash; done is sticky and silences all commands.
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        chk("done_set", {30'd0, done, remove}, 32'd2);
        cmd_or = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cmd_or = cmd_or | front | turn | remove;
        end
        chk("done_quiet", {31'd0, cmd_or}, 32'd0);
        chk("done_sticky", {31'd0, done}, 32'd1);

        // 256 removals: the counter must stop at all-ones.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1);
            for (int i = 0; i < REMOVE_CYCLES; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("count_saturate", {24'd0, trash_count}, 32'd255);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
